arb_rr_nhost: RTL and testbench

// - Parametrised N-host round-robin bus arbiter; next generation of the fixed 4-host arbiter.
// - Sits between NH CPU/test hosts and the single register-access device bus.
// - Adds: host count, timeout limit and flattened host buses as parameters; per-host timeout flag;

---
 rtl/arb_rr_nhost_if.sv | 40 ++++
 rtl/arb_rr_nhost.sv | 156 +++++++++++++++
 tb/tb_arb_rr_nhost.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_rr_nhost_if.sv
// Bus bundle for arb_rr_nhost: flattened host request buses plus the single device bus.
// The arbiter connects through the slave modport; hosts/device models use the master modport.
interface arb_rr_nhost_if #(
  parameter int NH = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 4,
  parameter int GW = $clog2(NH)
);
  logic [NH-1:0]    h_rd;
  logic [NH-1:0]    h_wr;
  logic [NH-1:0]    h_cpu;
  logic [NH*AW-1:0] h_addr;
  logic [NH*BW-1:0] h_be;
  logic [NH*DW-1:0] h_dwr;
  logic [DW-1:0]    h_drd;
  logic [2*NH-1:0]  h_ack;
  logic [AW-1:0]    add_bus;
  logic [BW-1:0]    byte_en;
  logic             cpu_bus;
  logic [DW-1:0]    data_bus_wr;
  logic             wr_bus;
  logic             rd_bus;
  logic [DW-1:0]    data_bus_rd;
  logic             ack_bus;
  logic [GW-1:0]    grant_id;
  logic             busy;

  modport slave (
    input  h_rd, h_wr, h_cpu, h_addr, h_be, h_dwr, data_bus_rd, ack_bus,
    output h_drd, h_ack, add_bus, byte_en, cpu_bus, data_bus_wr, wr_bus, rd_bus,
           grant_id, busy
  );

  modport master (
    output h_rd, h_wr, h_cpu, h_addr, h_be, h_dwr, data_bus_rd, ack_bus,
    input  h_drd, h_ack, add_bus, byte_en, cpu_bus, data_bus_wr, wr_bus, rd_bus,
           grant_id, busy
  );
endinterface

// File: rtl/arb_rr_nhost.sv
// N-host round-robin arbiter onto a single register-access device bus, with access timeout.
// Optional ARB_TIMEOUT_STAT_EN adds to_count/to_host timeout statistics outputs.
module arb_rr_nhost #(
  parameter int NH       = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int BW       = 4,
  parameter int TW       = 16,
  parameter int TO_LIMIT = (2**TW) - 2,
  parameter int GW       = $clog2(NH)
) (
  input  logic          clk,
  input  logic          reset_n,
  arb_rr_nhost_if.slave bus
`ifdef ARB_TIMEOUT_STAT_EN
  ,
  output logic [15:0]   to_count,
  output logic [GW-1:0] to_host
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, ACK = 2'd2} state_t;

  state_t          state_r, state_nx_s;
  logic [GW-1:0]   ptr_r, grant_r, win_idx_s, cand_s;
  logic            win_found_s, grant_start_s, to_hit_s, done_s;
  logic [NH-1:0]   req_s;
  logic [TW-1:0]   cnt_r;
  logic [AW-1:0]   addr_r;
  logic [BW-1:0]   be_r;
  logic            cpu_r, rd_r, wr_r, busy_r;
  logic [DW-1:0]   dwr_r, drd_r;
  logic [2*NH-1:0] ack_r, ack_nx_s;

  assign req_s         = bus.h_rd | bus.h_wr;
  assign to_hit_s      = (cnt_r == TW'(TO_LIMIT));
  assign done_s        = (state_r == ACC) && (bus.ack_bus || to_hit_s);
  assign grant_start_s = win_found_s && ((state_r == IDLE) || (state_r == ACK));

  // Rotating priority search: first requester after the last-granted host wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 1; k <= NH; k++) begin
      cand_s      = GW'((int'(ptr_r) + k) % NH);
      win_idx_s   = (req_s[cand_s] && !win_found_s) ? cand_s : win_idx_s;
      win_found_s = win_found_s | req_s[cand_s];
    end
  end

  // Next-state logic; arbitration happens in IDLE and in ACK so accesses chain without a gap.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (win_found_s) state_nx_s = ACC; else state_nx_s = IDLE;
      ACC:     if (done_s)      state_nx_s = ACK; else state_nx_s = ACC;
      ACK:     if (win_found_s) state_nx_s = ACC; else state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Completion pulse for the granted host; timeout flag only when the device stayed silent.
  always_comb begin
    ack_nx_s = '0;
    if (done_s) begin
      ack_nx_s[{grant_r, 1'b0}] = 1'b1;
      ack_nx_s[{grant_r, 1'b1}] = to_hit_s & ~bus.ack_bus;
    end else begin
      ack_nx_s = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_nx_s;
  end

  // Access cycle counter: runs only while waiting in ACC, saturating at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        cnt_r <= '0;
    else if ((state_r == ACC) && !done_s) cnt_r <= (&cnt_r) ? cnt_r : cnt_r + TW'(1'b1);
    else                                 cnt_r <= '0;
  end

  // Grant capture, device bus drive and read-data return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r   <= GW'(NH - 1);
      grant_r <= '0;
      addr_r  <= '0;
      be_r    <= '0;
      cpu_r   <= 1'b0;
      dwr_r   <= '0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      drd_r   <= '0;
      ack_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      ack_r  <= ack_nx_s;
      busy_r <= (state_nx_s != IDLE);
      if (grant_start_s) begin
        ptr_r   <= win_idx_s;
        grant_r <= win_idx_s;
        addr_r  <= bus.h_addr[win_idx_s*AW +: AW];
        be_r    <= bus.h_be[win_idx_s*BW +: BW];
        cpu_r   <= bus.h_cpu[win_idx_s];
        dwr_r   <= bus.h_dwr[win_idx_s*DW +: DW];
        // A host asking for both gets its read first; the write remains requested.
        rd_r    <= bus.h_rd[win_idx_s];
        wr_r    <= bus.h_wr[win_idx_s] & ~bus.h_rd[win_idx_s];
      end else if (done_s) begin
        addr_r <= '0;
        be_r   <= '0;
        cpu_r  <= 1'b0;
        dwr_r  <= '0;
        rd_r   <= 1'b0;
        wr_r   <= 1'b0;
        if (bus.ack_bus) drd_r <= bus.data_bus_rd;
      end
    end
  end

  assign bus.h_drd       = drd_r;
  assign bus.h_ack       = ack_r;
  assign bus.add_bus     = addr_r;
  assign bus.byte_en     = be_r;
  assign bus.cpu_bus     = cpu_r;
  assign bus.data_bus_wr = dwr_r;
  assign bus.wr_bus      = wr_r;
  assign bus.rd_bus      = rd_r;
  assign bus.grant_id    = grant_r;
  assign bus.busy        = busy_r;

`ifdef ARB_TIMEOUT_STAT_EN
  logic [15:0]   to_count_r;
  logic [GW-1:0] to_host_r;

  // Timed-out access statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_count_r <= '0;
      to_host_r  <= '0;
    end else if (done_s && to_hit_s && !bus.ack_bus) begin
      to_count_r <= (&to_count_r) ? to_count_r : to_count_r + 16'd1;
      to_host_r  <= grant_r;
    end
  end

  assign to_count = to_count_r;
  assign to_host  = to_host_r;
`endif

endmodule

// File: tb/tb_arb_rr_nhost.sv
// Self-checking bench for arb_rr_nhost: directed scenarios plus randomized accesses
// checked against a round-robin reference model.
module tb_arb_rr_nhost;
  localparam int NH = 4, AW = 32, DW = 32, BW = 4, TW = 16, TO_LIMIT = 14, GW = 2;

  logic          clk;
  logic          reset_n;
  int            n_cmp;
  int            n_fail;
  int            last_g;
  logic [DW-1:0] drd_exp;

  arb_rr_nhost_if #(.NH(NH), .AW(AW), .DW(DW), .BW(BW), .GW(GW)) bus_if ();

`ifdef ARB_TIMEOUT_STAT_EN
  logic [15:0]   to_count;
  logic [GW-1:0] to_host;
`endif

  arb_rr_nhost #(.NH(NH), .AW(AW), .DW(DW), .BW(BW), .TW(TW), .TO_LIMIT(TO_LIMIT), .GW(GW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
`ifdef ARB_TIMEOUT_STAT_EN
    ,
    .to_count(to_count),
    .to_host (to_host)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hosts();
    bus_if.h_rd        = '0;
    bus_if.h_wr        = '0;
    bus_if.h_cpu       = '0;
    bus_if.h_addr      = '0;
    bus_if.h_be        = '0;
    bus_if.h_dwr       = '0;
    bus_if.data_bus_rd = '0;
    bus_if.ack_bus     = 1'b0;
  endtask

  // Reference rule: first requesting host after the last-granted one, modulo NH.
  function automatic int exp_winner(int last, logic [NH-1:0] req);
    for (int k = 1; k <= NH; k++) begin
      if (req[(last + k) % NH]) return (last + k) % NH;
    end
    return -1;
  endfunction

  task automatic test_reset();
    clear_hosts();
    reset_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({bus_if.wr_bus, bus_if.rd_bus, bus_if.busy, bus_if.cpu_bus} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got wr/rd/busy/cpu=%b want 0000",
               {bus_if.wr_bus, bus_if.rd_bus, bus_if.busy, bus_if.cpu_bus});
    end
    n_cmp++;
    if (bus_if.h_ack !== 8'h00 || bus_if.h_drd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_host: got ack=%h drd=%h want 00/0", bus_if.h_ack, bus_if.h_drd);
    end
    n_cmp++;
    if ({bus_if.add_bus, bus_if.byte_en, bus_if.data_bus_wr, bus_if.grant_id} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got add=%h be=%h dwr=%h gnt=%0d want 0",
               bus_if.add_bus, bus_if.byte_en, bus_if.data_bus_wr, bus_if.grant_id);
    end
    reset_n = 1'b1;
    tick();
    last_g  = NH - 1;
    drd_exp = '0;
  endtask

  task automatic test_basic_write();
    bus_if.h_wr[0]          = 1'b1;
    bus_if.h_cpu[0]         = 1'b1;
    bus_if.h_addr[0 +: AW]  = 32'h0000_0100;
    bus_if.h_be[0 +: BW]    = 4'hF;
    bus_if.h_dwr[0 +: DW]   = 32'hCAFE_0001;
    tick();
    n_cmp++;
    if ({bus_if.wr_bus, bus_if.rd_bus, bus_if.busy, bus_if.cpu_bus} !== 4'b1011) begin
      n_fail++;
      $display("FAIL wr_strobe: got wr/rd/busy/cpu=%b want 1011",
               {bus_if.wr_bus, bus_if.rd_bus, bus_if.busy, bus_if.cpu_bus});
    end
    n_cmp++;
    if (bus_if.add_bus !== 32'h100 || bus_if.data_bus_wr !== 32'hCAFE_0001 ||
        bus_if.byte_en !== 4'hF || bus_if.grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL wr_bus: got add=%h dwr=%h be=%h gnt=%0d want 100/cafe0001/f/0",
               bus_if.add_bus, bus_if.data_bus_wr, bus_if.byte_en, bus_if.grant_id);
    end
    last_g = 0;
    repeat (2) tick();
    n_cmp++;
    if (bus_if.wr_bus !== 1'b1 || bus_if.h_ack !== 8'h00) begin
      n_fail++;
      $display("FAIL wr_hold: got wr=%b ack=%h want 1/00", bus_if.wr_bus, bus_if.h_ack);
    end
    bus_if.ack_bus = 1'b1;
    tick();
    bus_if.ack_bus = 1'b0;
    n_cmp++;
    if (bus_if.h_ack !== 8'h01 || bus_if.wr_bus !== 1'b0 || bus_if.add_bus !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_ack: got ack=%h wr=%b add=%h want 01/0/0",
               bus_if.h_ack, bus_if.wr_bus, bus_if.add_bus);
    end
    bus_if.h_wr[0] = 1'b0;
    tick();
    n_cmp++;
    if (bus_if.h_ack !== 8'h00 || bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done: got ack=%h busy=%b want 00/0", bus_if.h_ack, bus_if.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2*NH-1:0] ea;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    last_g  = NH - 1;
    drd_exp = '0;
    for (int i = 0; i < NH; i++) bus_if.h_addr[i*AW +: AW] = 32'(i + 1) << 12;
    bus_if.h_wr = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      int g;
      g = i % NH;
      n_cmp++;
      if (bus_if.grant_id !== GW'(g) || bus_if.wr_bus !== 1'b1 ||
          bus_if.add_bus !== (32'(g + 1) << 12)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got gnt=%0d wr=%b add=%h want %0d/1/%h",
                 i, bus_if.grant_id, bus_if.wr_bus, bus_if.add_bus, g, 32'(g + 1) << 12);
      end
      bus_if.ack_bus = 1'b1;
      tick();
      bus_if.ack_bus = 1'b0;
      ea = '0;
      ea[2*g] = 1'b1;
      n_cmp++;
      if (bus_if.h_ack !== ea) begin
        n_fail++;
        $display("FAIL rr_ack%0d: got %h want %h", i, bus_if.h_ack, ea);
      end
      if (i == 4) bus_if.h_wr = '0;
      tick();
    end
    last_g = 0;
    n_cmp++;
    if (bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle: got busy=%b want 0", bus_if.busy);
    end
  endtask

  task automatic test_read_host2();
    bus_if.h_rd[2]          = 1'b1;
    bus_if.h_addr[2*AW +: AW] = 32'h0000_0204;
    bus_if.data_bus_rd      = 32'h1111_2222;
    tick();
    n_cmp++;
    if (bus_if.rd_bus !== 1'b1 || bus_if.wr_bus !== 1'b0 || bus_if.grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL rd_strobe: got rd=%b wr=%b gnt=%0d want 1/0/2",
               bus_if.rd_bus, bus_if.wr_bus, bus_if.grant_id);
    end
    last_g = 2;
    tick();
    bus_if.data_bus_rd = 32'hDEAD_BEEF;
    bus_if.ack_bus     = 1'b1;
    tick();
    bus_if.ack_bus     = 1'b0;
    bus_if.data_bus_rd = 32'h0;
    drd_exp            = 32'hDEAD_BEEF;
    n_cmp++;
    if (bus_if.h_drd !== drd_exp || bus_if.h_ack !== 8'h10) begin
      n_fail++;
      $display("FAIL rd_data: got drd=%h ack=%h want deadbeef/10", bus_if.h_drd, bus_if.h_ack);
    end
    bus_if.h_rd[2] = 1'b0;
    tick();
    bus_if.data_bus_rd = 32'h5555_AAAA;
    bus_if.ack_bus     = 1'b1;
    tick();
    bus_if.ack_bus     = 1'b0;
    bus_if.data_bus_rd = 32'h0;
    tick();
    n_cmp++;
    if (bus_if.h_drd !== drd_exp || bus_if.h_ack !== 8'h00 || bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack: got drd=%h ack=%h busy=%b want %h/00/0",
               bus_if.h_drd, bus_if.h_ack, bus_if.busy, drd_exp);
    end
  endtask

  task automatic test_timeout();
    int n;
    bus_if.h_rd[1]     = 1'b1;
    bus_if.data_bus_rd = 32'h0BAD_F00D;
    tick();
    n = 0;
    while (bus_if.rd_bus === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    last_g = 1;
    n_cmp++;
    if (n !== TO_LIMIT + 1) begin
      n_fail++;
      $display("FAIL to_len: got %0d access cycles want %0d", n, TO_LIMIT + 1);
    end
    n_cmp++;
    if (bus_if.h_ack !== 8'h0C || bus_if.h_drd !== drd_exp) begin
      n_fail++;
      $display("FAIL to_ack: got ack=%h drd=%h want 0c/%h", bus_if.h_ack, bus_if.h_drd, drd_exp);
    end
    bus_if.h_rd[1]     = 1'b0;
    bus_if.data_bus_rd = 32'h0;
    tick();
    n_cmp++;
    if (bus_if.h_ack !== 8'h00) begin
      n_fail++;
      $display("FAIL to_pulse: got ack=%h want 00", bus_if.h_ack);
    end
  endtask

  task automatic test_ack_at_timeout();
    bus_if.h_wr[3] = 1'b1;
    tick();
    repeat (TO_LIMIT) tick();
    n_cmp++;
    if (bus_if.wr_bus !== 1'b1) begin
      n_fail++;
      $display("FAIL late_acc: got wr=%b want 1", bus_if.wr_bus);
    end
    bus_if.ack_bus     = 1'b1;
    bus_if.data_bus_rd = 32'h600D_0003;
    tick();
    bus_if.ack_bus     = 1'b0;
    bus_if.data_bus_rd = 32'h0;
    drd_exp            = 32'h600D_0003;
    last_g             = 3;
    n_cmp++;
    if (bus_if.h_ack !== 8'h40 || bus_if.h_drd !== drd_exp) begin
      n_fail++;
      $display("FAIL late_ack: got ack=%h drd=%h want 40/%h", bus_if.h_ack, bus_if.h_drd, drd_exp);
    end
    bus_if.h_wr[3] = 1'b0;
    tick();
  endtask

  task automatic test_rd_wr_same();
    bus_if.h_rd[0] = 1'b1;
    bus_if.h_wr[0] = 1'b1;
    tick();
    n_cmp++;
    if (bus_if.rd_bus !== 1'b1 || bus_if.wr_bus !== 1'b0 || bus_if.grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL rw_read: got rd=%b wr=%b gnt=%0d want 1/0/0",
               bus_if.rd_bus, bus_if.wr_bus, bus_if.grant_id);
    end
    bus_if.ack_bus = 1'b1;
    tick();
    bus_if.ack_bus = 1'b0;
    drd_exp        = 32'h0;
    bus_if.h_rd[0] = 1'b0;
    tick();
    n_cmp++;
    if (bus_if.wr_bus !== 1'b1 || bus_if.rd_bus !== 1'b0 || bus_if.grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL rw_write: got rd=%b wr=%b gnt=%0d want 0/1/0",
               bus_if.rd_bus, bus_if.wr_bus, bus_if.grant_id);
    end
    bus_if.ack_bus = 1'b1;
    tick();
    bus_if.ack_bus = 1'b0;
    bus_if.h_wr[0] = 1'b0;
    tick();
    last_g = 0;
  endtask

  task automatic test_reset_mid();
    bus_if.h_wr[0] = 1'b1;
    bus_if.h_wr[2] = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (bus_if.wr_bus !== 1'b1 || bus_if.grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_pre: got wr=%b gnt=%0d want 1/2", bus_if.wr_bus, bus_if.grant_id);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_if.wr_bus, bus_if.busy, bus_if.grant_id, bus_if.h_ack, bus_if.add_bus} !== 44'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got wr=%b busy=%b gnt=%0d ack=%h add=%h want 0",
               bus_if.wr_bus, bus_if.busy, bus_if.grant_id, bus_if.h_ack, bus_if.add_bus);
    end
    #2;
    reset_n = 1'b1;
    drd_exp = '0;
    tick();
    n_cmp++;
    if (bus_if.grant_id !== 2'd0 || bus_if.wr_bus !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_release: got gnt=%0d wr=%b want 0/1", bus_if.grant_id, bus_if.wr_bus);
    end
    bus_if.ack_bus = 1'b1;
    tick();
    bus_if.ack_bus = 1'b0;
    bus_if.h_wr    = '0;
    tick();
    last_g = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [NH-1:0]   rd, wr;
      logic [2*NH-1:0] ea;
      logic [DW-1:0]   rdata;
      logic            to_exp;
      int              w, lat;
      do begin
        rd = NH'($urandom);
        wr = NH'($urandom);
      end while ((rd | wr) == '0);
      for (int i = 0; i < NH; i++) begin
        bus_if.h_addr[i*AW +: AW] = $urandom;
        bus_if.h_dwr[i*DW +: DW]  = $urandom;
        bus_if.h_be[i*BW +: BW]   = BW'($urandom);
      end
      bus_if.h_cpu = NH'($urandom);
      bus_if.h_rd  = rd;
      bus_if.h_wr  = wr;
      w = exp_winner(last_g, rd | wr);
      tick();
      n_cmp++;
      if (bus_if.grant_id !== GW'(w) || bus_if.rd_bus !== rd[w] ||
          bus_if.wr_bus !== (wr[w] & ~rd[w])) begin
        n_fail++;
        $display("FAIL rnd_grant%0d: got gnt=%0d rd=%b wr=%b want %0d/%b/%b", it,
                 bus_if.grant_id, bus_if.rd_bus, bus_if.wr_bus, w, rd[w], wr[w] & ~rd[w]);
      end
      n_cmp++;
      if (bus_if.add_bus !== bus_if.h_addr[w*AW +: AW] || bus_if.data_bus_wr !== bus_if.h_dwr[w*DW +: DW] ||
          bus_if.byte_en !== bus_if.h_be[w*BW +: BW] || bus_if.cpu_bus !== bus_if.h_cpu[w]) begin
        n_fail++;
        $display("FAIL rnd_bus%0d: got add=%h dwr=%h be=%h cpu=%b want %h/%h/%h/%b", it,
                 bus_if.add_bus, bus_if.data_bus_wr, bus_if.byte_en, bus_if.cpu_bus,
                 bus_if.h_addr[w*AW +: AW], bus_if.h_dwr[w*DW +: DW],
                 bus_if.h_be[w*BW +: BW], bus_if.h_cpu[w]);
      end
      last_g = w;
      if ($urandom_range(0, 1) == 1) begin
        bus_if.h_rd = '0;
        bus_if.h_wr = '0;
      end
      lat    = $urandom_range(0, 5);
      to_exp = (lat == 5);
      if (to_exp) begin
        bus_if.data_bus_rd = $urandom;
        repeat (TO_LIMIT + 1) tick();
      end else begin
        repeat (lat) tick();
        rdata              = $urandom;
        bus_if.data_bus_rd = rdata;
        bus_if.ack_bus     = 1'b1;
        tick();
        bus_if.ack_bus     = 1'b0;
        drd_exp            = rdata;
      end
      ea = '0;
      ea[2*w]     = 1'b1;
      ea[2*w + 1] = to_exp;
      n_cmp++;
      if (bus_if.h_ack !== ea || bus_if.h_drd !== drd_exp) begin
        n_fail++;
        $display("FAIL rnd_ack%0d: got ack=%h drd=%h want %h/%h", it,
                 bus_if.h_ack, bus_if.h_drd, ea, drd_exp);
      end
      bus_if.h_rd        = '0;
      bus_if.h_wr        = '0;
      bus_if.data_bus_rd = '0;
      tick();
      n_cmp++;
      if (bus_if.busy !== 1'b0 || bus_if.h_ack !== 8'h00) begin
        n_fail++;
        $display("FAIL rnd_idle%0d: got busy=%b ack=%h want 0/00", it, bus_if.busy, bus_if.h_ack);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    last_g  = NH - 1;
    drd_exp = '0;
    reset_n = 1'b1;
    clear_hosts();
    #3;
    test_reset();
    test_basic_write();
    test_round_robin();
    test_read_host2();
    test_timeout();
    test_ack_at_timeout();
    test_rd_wr_same();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
